// File: rtl/shot_clock_down.sv
// Shot-clock BCD down-counter with run/pause/expire control and char ROM addressing.
// Optional low-time warn output enabled by defining SHOT_CLOCK_WARN_EN.
module shot_clock_down #(
    parameter logic [26:0] TICK_DIV   = 27'd100000000,
    parameter logic [7:0]  LOAD_VALUE = 8'h24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       expired,
    output logic       expire_pulse,
    output logic [8:0] tens_rom_addr,
    output logic [8:0] ones_rom_addr
`ifdef SHOT_CLOCK_WARN_EN
    ,
    output logic       warn
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] PAUSE   = 2'd2;
    localparam logic [1:0] EXPIRED = 2'd3;

    logic [1:0]  state, state_d;
    logic [26:0] presc, presc_d;
    logic [3:0]  tens_d, ones_d;
    logic        pulse_d;
    logic        tick;
    logic        go;

    assign tick = (state == RUN) && (presc == TICK_DIV - 27'd1);
    // pause outranks start even in states where pause itself does nothing
    assign go   = start && !pause && ({tens, ones} != 8'h00);

    always_comb begin
        state_d = state;
        presc_d = presc;
        tens_d  = tens;
        ones_d  = ones;
        pulse_d = 1'b0;
        if (load) begin
            tens_d  = LOAD_VALUE[7:4];
            ones_d  = LOAD_VALUE[3:0];
            presc_d = 27'd0;
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, PAUSE: begin
                    if (go) state_d = RUN;
                end
                RUN: begin
                    presc_d = tick ? 27'd0 : presc + 27'd1;
                    if (tick) begin
                        if (ones != 4'd0) begin
                            ones_d = ones - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens - 4'd1;
                        end
                    end
                    if (tick && {tens_d, ones_d} == 8'h00) begin
                        state_d = EXPIRED;
                        pulse_d = 1'b1;
                    end else if (pause) begin
                        state_d = PAUSE;
                    end
                end
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            presc        <= 27'd0;
            tens         <= LOAD_VALUE[7:4];
            ones         <= LOAD_VALUE[3:0];
            expire_pulse <= 1'b0;
        end else begin
            state        <= state_d;
            presc        <= presc_d;
            tens         <= tens_d;
            ones         <= ones_d;
            expire_pulse <= pulse_d;
        end
    end

`ifdef SHOT_CLOCK_WARN_EN
    logic warn_d;

    assign warn_d = ((state_d == RUN) || (state_d == PAUSE))
                    && ({tens_d, ones_d} <= 8'h05);

    always_ff @(posedge clk) begin
        if (!rst) warn <= 1'b0;
        else      warn <= warn_d;
    end
`endif

    assign running       = (state == RUN);
    assign expired       = (state == EXPIRED);
    assign tens_rom_addr = {2'b00, tens, 3'b000} + 9'h180;
    assign ones_rom_addr = {2'b00, ones, 3'b000} + 9'h180;

endmodule
